// File: rtl/dram_port_arbiter_pkg.sv
// Shared state encoding and default bus widths for the DRAM port arbiter
// and the blocks that sit on either side of it.
package dram_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_write_queue.sv
// Small synchronous FIFO of {addr, data} write beats with occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module arb_write_queue
    import dram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = mem[rd_ptr][EW-1:DATA_W];
    assign head_data = mem[rd_ptr][DATA_W-1:0];

    // Contents are cleared with the pointers so a reset mid-burst leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_addr, push_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one registered DRAM command port between a read stream and a queued
// write stream with bursting and turnaround. ARB_STATS_EN adds stall counters.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WQ_DEPTH  = 4,
    parameter int MAX_BURST = 8,
    parameter int TURN_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       rd_stall_cnt,
    output logic [15:0]       wr_stall_cnt,
`endif
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              dram_en,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              busy
);

    localparam int CW = $clog2(WQ_DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam logic [CW-1:0] HW_LEVEL  = CW'(WQ_DEPTH - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [BW-1:0]     burst_cnt;
    logic [TW-1:0]     turn_cnt;
    logic              push;
    logic              pop;
    logic              issue_rd;
    logic              issue_wr;
    logic              hw;
    logic              burst_full;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    arb_write_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WQ_DEPTH)
    ) u_wq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign wr_ready   = !full;
    assign push       = wr_req && !full;
    assign pop        = issue_wr;
    assign rd_gnt     = issue_rd;
    assign hw         = (count >= HW_LEVEL);
    assign burst_full = (burst_cnt == BURST_MAX);
    assign count_next = count + CW'(push) - CW'(pop);

    // Exit cycles from RD and WR issue nothing, so every direction change
    // always leaves at least one dead cycle before TURN starts counting.
    always_comb begin
        state_next = state;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (hw)              state_next = WR;
                else if (rd_req)     state_next = RD;
                else if (!empty)     state_next = WR;
            end
            RD: begin
                if (!rd_req || hw || (burst_full && !empty)) state_next = TURN;
                else                                         issue_rd   = 1'b1;
            end
            WR: begin
                if (empty || (burst_full && rd_req)) state_next = TURN;
                else                                 issue_wr   = 1'b1;
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bursts always start from IDLE, so holding the counter clear there covers every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            turn_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE)
                burst_cnt <= '0;
            else if ((issue_rd || issue_wr) && !burst_full)
                burst_cnt <= burst_cnt + BW'(1);
            turn_cnt <= (state == TURN && turn_cnt != TURN_LAST) ? turn_cnt + TW'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dram_en    <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dram_en  <= issue_rd || issue_wr;
            dram_we  <= issue_wr;
            rd_valid <= dram_en && !dram_we;
            busy     <= (state_next != IDLE) || (count_next != '0);
            if (issue_rd) begin
                dram_addr <= rd_addr;
            end else if (issue_wr) begin
                dram_addr  <= head_addr;
                dram_wdata <= head_data;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_stall_cnt <= '0;
            wr_stall_cnt <= '0;
        end else if (stats_clr) begin
            rd_stall_cnt <= '0;
            wr_stall_cnt <= '0;
        end else begin
            if (rd_req && !rd_gnt && rd_stall_cnt != 16'hFFFF)
                rd_stall_cnt <= rd_stall_cnt + 16'd1;
            if (wr_req && !wr_ready && wr_stall_cnt != 16'hFFFF)
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: directed per-cycle vectors push
// expected DRAM commands and read-valid cycles; a negedge monitor retires them.
module tb_dram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              dram_en;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              busy;
`ifdef ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       rd_stall_cnt;
    logic [15:0]       wr_stall_cnt;
`endif

    dram_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ARB_STATS_EN
        .stats_clr    (stats_clr),
        .rd_stall_cnt (rd_stall_cnt),
        .wr_stall_cnt (wr_stall_cnt),
`endif
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .dram_en    (dram_en),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } cmd_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbeat_t;

    cmd_t   cmd_q[$];
    int     rv_q[$];
    wbeat_t model_q[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] next_ra;
    logic [ADDR_W-1:0] next_wa;
    logic [DATA_W-1:0] next_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus: rq/wq drive the requesters; eg/er are the required
    // rd_gnt/wr_ready this cycle; ep marks the cycle a queued write must issue.
    task automatic applyStimulus(input logic rq, input logic wq, input logic eg,
                                 input logic er, input logic ep);
        wbeat_t b;
        @(posedge clk);
        #1;
        rd_req  = rq;
        rd_addr = next_ra;
        wr_req  = wq;
        wr_addr = next_wa;
        wr_data = next_wd;
        if (eg) begin
            cmd_q.push_back('{1'b0, next_ra, 64'h0, cyc + 1});
            rv_q.push_back(cyc + 2);
            next_ra = next_ra + 10'd1;
        end
        if (ep) begin
            b = model_q.pop_front();
            cmd_q.push_back('{1'b1, b.addr, b.data, cyc + 1});
        end
        if (wq && er) begin
            model_q.push_back('{next_wa, next_wd});
            next_wa = next_wa + 10'd1;
            next_wd = {$urandom(), $urandom()};
        end
        @(negedge clk);
        checkOutput("rd_gnt", 128'(rd_gnt), 128'(eg));
        checkOutput("wr_ready", 128'(wr_ready), 128'(er));
    endtask

    // Monitor retires expected commands and read-valid pulses as the DUT presents them.
    always @(negedge clk) begin
        cmd_t e;
        if (!rst) begin
            if (dram_en) begin
                if (cmd_q.size() == 0) begin
                    checkOutput("spurious_dram_en", 128'(dram_en), 128'(0));
                end else begin
                    e = cmd_q.pop_front();
                    checkOutput("cmd_fields",
                                128'({dram_we, dram_addr, (dram_we ? dram_wdata : 64'h0)}),
                                128'({e.we, e.addr, (e.we ? e.data : 64'h0)}));
                    checkOutput("cmd_cycle", 128'(cyc), 128'(e.cyc));
                end
            end else if (cmd_q.size() > 0 && cmd_q[0].cyc <= cyc) begin
                checkOutput("missing_dram_en", 128'(dram_en), 128'(1));
                void'(cmd_q.pop_front());
            end
            if (rd_valid) begin
                if (rv_q.size() == 0) begin
                    checkOutput("spurious_rd_valid", 128'(rd_valid), 128'(0));
                end else begin
                    checkOutput("rd_valid_cycle", 128'(cyc), 128'(rv_q.pop_front()));
                end
            end else if (rv_q.size() > 0 && rv_q[0] <= cyc) begin
                checkOutput("missing_rd_valid", 128'(rd_valid), 128'(1));
                void'(rv_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        next_ra = 10'h000;
        next_wa = 10'h200;
        next_wd = {$urandom(), $urandom()};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_dram_en", 128'(dram_en), 128'(0));
        checkOutput("reset_dram_we", 128'(dram_we), 128'(0));
        checkOutput("reset_dram_addr", 128'(dram_addr), 128'(0));
        checkOutput("reset_dram_wdata", 128'(dram_wdata), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_rd_valid", 128'(rd_valid), 128'(0));
        checkOutput("reset_wr_ready", 128'(wr_ready), 128'(1));
`ifdef ARB_STATS_EN
        checkOutput("reset_rd_stall", 128'(rd_stall_cnt), 128'(0));
        checkOutput("reset_wr_stall", 128'(wr_stall_cnt), 128'(0));
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // 12-beat read stream: burst limit does not stop reads while the queue is empty.
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        checkOutput("busy_in_rd", 128'(busy), 128'(1));
        repeat (11) applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("busy_idle", 128'(busy), 128'(0));

        // Reads with one pending write: burst limit forces turnaround, but IDLE
        // still prefers the read stream until it goes quiet.
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 1, 1, 1, 0);
        repeat (6) applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(1, 0, 0, 1, 0);
        repeat (2) applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("busy_queue_pending", 128'(busy), 128'(1));
        applyStimulus(0, 0, 0, 1, 1);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("busy_after_drain", 128'(busy), 128'(0));

`ifdef ARB_STATS_EN
        @(posedge clk);
        #1 stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        checkOutput("stats_clr_rd", 128'(rd_stall_cnt), 128'(0));
        checkOutput("stats_clr_wr", 128'(wr_stall_cnt), 128'(0));
`endif

        // Writes every cycle during a read burst: watermark ends the burst, queue fills.
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        repeat (2) applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 1);
        repeat (2) applyStimulus(1, 1, 0, 1, 1);
        repeat (3) applyStimulus(1, 0, 0, 1, 1);
        repeat (3) applyStimulus(1, 0, 0, 1, 0);
        repeat (2) applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

`ifdef ARB_STATS_EN
        checkOutput("rd_stall_cnt", 128'(rd_stall_cnt), 128'(13));
        checkOutput("wr_stall_cnt", 128'(wr_stall_cnt), 128'(3));
        @(posedge clk);
        #1 stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        checkOutput("stats_clr_wr_after", 128'(wr_stall_cnt), 128'(0));
`endif

        // 20 random write beats with simultaneous push/pop holding the count at 2.
        repeat (2) applyStimulus(0, 1, 0, 1, 0);
        repeat (18) applyStimulus(0, 1, 0, 1, 1);
        repeat (2) applyStimulus(0, 0, 0, 1, 1);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

        // Write burst limit with a read waiting: eight beats, then hand over.
        repeat (2) applyStimulus(0, 1, 0, 1, 0);
        repeat (3) applyStimulus(0, 1, 0, 1, 1);
        repeat (5) applyStimulus(1, 1, 0, 1, 1);
        repeat (3) applyStimulus(1, 0, 0, 1, 0);
        repeat (2) applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        repeat (2) applyStimulus(0, 0, 0, 1, 1);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

        // Reset in the middle of a read burst after three grants.
        applyStimulus(1, 0, 0, 1, 0);
        repeat (3) applyStimulus(1, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cmd_q.delete();
        rv_q.delete();
        model_q.delete();
        #1;
        checkOutput("midreset_dram_en", 128'(dram_en), 128'(0));
        checkOutput("midreset_dram_addr", 128'(dram_addr), 128'(0));
        checkOutput("midreset_busy", 128'(busy), 128'(0));
        checkOutput("midreset_rd_gnt", 128'(rd_gnt), 128'(0));
        @(negedge clk);
        checkOutput("midreset_rd_valid", 128'(rd_valid), 128'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rd_req = 1'b0;
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 128'(cmd_q.size() + rv_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
